boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter: TIMEOUT, default 1000, number of consecutive stalled cycles in LOAD/CHECK before an abort (range 2..65535).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin a program load.
REQ-005 base_addr  input  8  first memory address written; also the CPU start PC.
REQ-006 len_m1  input  8  program length minus one; 0..255 means 1..256 bytes.
REQ-007 byte_valid  input  1  host byte available on byte_data.
REQ-008 byte_data  input  8  host program/checksum byte.
REQ-009 byte_ready  output  1  loader accepts byte this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
REQ-010 mem_we  output  1  one-cycle program-memory write strobe.
REQ-011 mem_addr  output  8  write address.
REQ-012 mem_data  output  8  write data.
REQ-013 pc_load  output  1  one-cycle strobe to load the CPU PC.
REQ-014 pc_value  output  8  PC value, valid while pc_load=1.
REQ-015 cpu_run  output  1  1 = CPU released; 0 = CPU held.
REQ-016 busy  output  1  1 in LOAD, CHECK or LAUNCH.
REQ-017 done  output  1  1 in RUN.
REQ-018 error  output  1  1 in ERROR.

Function
REQ-019 States: IDLE, LOAD, CHECK, LAUNCH, RUN, ERROR. All outputs are registered or decoded from state only; no input-to-output combinational path except that byte_ready is a decode of state.
REQ-020 IDLE: byte_ready=0, cpu_run=0. On start=1, latch base_addr and len_m1, set wr_ptr=base_addr, count=0, sum=0, stall=0, then go to LOAD.
REQ-021 LOAD: byte_ready=1. On a transfer at edge k, during the cycle after edge k: mem_we=1, mem_addr=wr_ptr, mem_data=byte_data. At edge k also increment wr_ptr mod 256, set sum=(sum+byte_data) mod 256, and increment count.
REQ-022 LOAD exit: a transfer with count==latched len_m1 moves to CHECK; the memory write for that byte still occurs.
REQ-023 Address wrap: wr_ptr 0xFF increments to 0x00 with no error.
REQ-024 CHECK: byte_ready=1 and no memory write. On a transfer, (sum+byte_data) mod 256 == 0 moves to LAUNCH; any other value moves to ERROR.
REQ-025 LAUNCH: lasts one cycle with pc_load=1 and pc_value=latched base_addr, then goes to RUN.
REQ-026 RUN: cpu_run=1 and done=1, held until reset or start.
REQ-027 ERROR: error=1, cpu_run=0, byte_ready=0, held until reset or start.
REQ-028 start in RUN or ERROR restarts the load exactly as in REQ-020; cpu_run, done and error are 0 in the cycle after that edge.
REQ-029 start in LOAD, CHECK or LAUNCH is ignored.
REQ-030 Stall counter (16 bits):
- cleared on entry to LOAD and on every transfer;
- incremented in each LOAD/CHECK cycle with no transfer;
- a no-transfer cycle with stall==TIMEOUT-1 moves to ERROR, so error rises after exactly TIMEOUT consecutive stalled cycles.
REQ-031 A transfer on the same edge that the timeout would fire wins; the timeout does not fire.
REQ-032 mem_we=0 in every cycle not covered by REQ-021; pc_load=0 outside LAUNCH.
REQ-033 A byte presented while byte_ready=0 is not consumed and has no effect.

Reset
REQ-034 reset=1 at a rising edge forces IDLE in any state, including mid-LOAD, taking priority over start and transfers.
REQ-035 Reset values: byte_ready=0, mem_we=0, mem_addr=0x00, mem_data=0x00, pc_load=0, pc_value=0x00, cpu_run=0, busy=0, done=0, error=0; internal wr_ptr, count, sum and stall are 0.
REQ-036 A pending mem_we for a byte accepted on the edge where reset is asserted is suppressed.

Verification
REQ-037 Nominal load: base_addr=0x10, len_m1=2, bytes 0x01,0x02,0x03, checksum 0xFA -> writes (0x10,0x01),(0x11,0x02),(0x12,0x03); pc_load=1 with pc_value=0x10 for one cycle; then cpu_run=1 and done=1.
REQ-038 Bad checksum: same load with checksum 0x00 -> three writes occur, no pc_load, error=1, cpu_run stays 0.
REQ-039 Wrap: base_addr=0xFE, len_m1=2, bytes 0xAA,0xBB,0xCC, checksum 0xCF -> writes at 0xFE, 0xFF, 0x00; cpu_run=1.
REQ-040 Stall: TIMEOUT=8, byte_valid held 0 after one accepted byte -> error=1 exactly 8 cycles after that byte's edge; a byte offered on the 8th stalled cycle instead keeps the block in LOAD.
REQ-041 Reset mid-load: reset after 2 of 4 bytes -> all outputs at reset values next cycle and no further writes; a fresh start then completes a full load.
REQ-042 Restart from RUN: start pulse while cpu_run=1 -> cpu_run=0 next cycle, byte_ready=1, and a reload completes normally with a new pc_load.

Source files
------------

// File: rtl/boot_loader.sv
// Host-to-memory program loader: streams len_m1+1 bytes into memory from base_addr, verifies a
// two's-complement checksum byte, then loads the CPU PC and releases the CPU; stalls abort after TIMEOUT cycles.
module boot_loader #(
   parameter int TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] base_addr,
   input  logic [7:0] len_m1,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       pc_load,
   output logic [7:0] pc_value,
   output logic       cpu_run,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_LAUNCH,
      S_RUN,
      S_ERROR
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [7:0]  base_q;
   logic [7:0]  len_q;
   logic [7:0]  wr_ptr;
   logic [7:0]  count;
   logic [7:0]  sum;
   logic [15:0] stall;

   logic        xfer;
   logic        can_start;
   logic        stall_out;
   logic [7:0]  sum_nxt;

   assign xfer      = byte_valid && byte_ready;
   assign can_start = start && (state == S_IDLE || state == S_RUN || state == S_ERROR);
   assign stall_out = !xfer && (stall == STALL_MAX);
   assign sum_nxt   = sum + byte_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      busy       = 1'b0;
      pc_load    = 1'b0;
      cpu_run    = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (xfer && (count == len_q)) state_nxt = S_CHECK;
            else if (stall_out)           state_nxt = S_ERROR;
         end
         S_CHECK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (xfer)           state_nxt = (sum_nxt == 8'h00) ? S_LAUNCH : S_ERROR;
            else if (stall_out) state_nxt = S_ERROR;
         end
         S_LAUNCH: begin
            busy      = 1'b1;
            pc_load   = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            cpu_run = 1'b1;
            done    = 1'b1;
            if (start) state_nxt = S_LOAD;
         end
         S_ERROR: begin
            error = 1'b1;
            if (start) state_nxt = S_LOAD;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign pc_value = base_q;

   // Reset clears the write strobe too, so a byte accepted on the reset edge never reaches memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         base_q   <= 8'h00;
         len_q    <= 8'h00;
         wr_ptr   <= 8'h00;
         count    <= 8'h00;
         sum      <= 8'h00;
         stall    <= 16'h0000;
         mem_we   <= 1'b0;
         mem_addr <= 8'h00;
         mem_data <= 8'h00;
      end else begin
         mem_we <= 1'b0;
         if (can_start) begin
            base_q <= base_addr;
            len_q  <= len_m1;
            wr_ptr <= base_addr;
            count  <= 8'h00;
            sum    <= 8'h00;
            stall  <= 16'h0000;
         end else if (state == S_LOAD || state == S_CHECK) begin
            if (xfer) begin
               stall <= 16'h0000;
               if (state == S_LOAD) begin
                  mem_we   <= 1'b1;
                  mem_addr <= wr_ptr;
                  mem_data <= byte_data;
                  wr_ptr   <= wr_ptr + 8'h01;
                  sum      <= sum_nxt;
                  count    <= count + 8'h01;
               end
            end else begin
               stall <= stall + 16'h0001;
            end
         end
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed scenarios plus randomized loads scored against a transaction-level model.
module tb_boot_loader;

   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] base_addr;
   logic [7:0] len_m1;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_data;
   logic       pc_load;
   logic [7:0] pc_value;
   logic       cpu_run;
   logic       busy;
   logic       done;
   logic       error;

   boot_loader #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len_m1(len_m1),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .pc_load(pc_load), .pc_value(pc_value), .cpu_run(cpu_run),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [15:0] wr_q[$];
   logic [7:0]  pc_q[$];
   logic [7:0]  payload[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_data});
      if (pc_load === 1'b1) pc_q.push_back(pc_value);
   end

   task automatic check_reset_vals(input string tag);
      check({tag, ":byte_ready"}, byte_ready, 0);
      check({tag, ":mem_we"}, mem_we, 0);
      check({tag, ":mem_addr"}, mem_addr, 0);
      check({tag, ":mem_data"}, mem_data, 0);
      check({tag, ":pc_load"}, pc_load, 0);
      check({tag, ":pc_value"}, pc_value, 0);
      check({tag, ":cpu_run"}, cpu_run, 0);
      check({tag, ":busy"}, busy, 0);
      check({tag, ":done"}, done, 0);
      check({tag, ":error"}, error, 0);
   endtask

   // Base/length inputs are scrambled right after the pulse to prove they were latched.
   task automatic pulse_start(input logic [7:0] b, input logic [7:0] l);
      base_addr = b;
      len_m1    = l;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      base_addr = 8'($urandom);
      len_m1    = 8'($urandom);
   endtask

   task automatic send(input logic [7:0] b, input int max_gap);
      int gap;
      int waited;
      bit ok;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = b;
      ok     = 1'b0;
      waited = 0;
      while (!ok && waited < 20) begin
         if (byte_ready === 1'b1) ok = 1'b1;
         @(negedge clk);
         waited++;
      end
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      check("handshake", ok, 1);
   endtask

   task automatic run_load(input logic [7:0] base, input logic [7:0] chk, input int max_gap,
                           input bit poke_start, input string tag);
      int s;
      int bad;
      bit good;
      logic [7:0] a;
      wr_q.delete();
      pc_q.delete();
      pulse_start(base, 8'(payload.size() - 1));
      check({tag, ":start_busy"}, busy, 1);
      check({tag, ":start_ready"}, byte_ready, 1);
      check({tag, ":start_run"}, {cpu_run, done, error}, 0);
      s = 0;
      foreach (payload[i]) begin
         s += int'(payload[i]);
         send(payload[i], max_gap);
         if (poke_start && i == 0) begin
            start     = 1'b1;
            base_addr = ~base;
            len_m1    = 8'h00;
            @(negedge clk);
            start     = 1'b0;
         end
      end
      send(chk, max_gap);
      good = ((s + int'(chk)) % 256) == 0;
      if (good) begin
         check({tag, ":pc_load"}, pc_load, 1);
         check({tag, ":pc_value"}, pc_value, base);
         check({tag, ":launch_run"}, cpu_run, 0);
         @(negedge clk);
         check({tag, ":run"}, {cpu_run, done, busy, pc_load, error}, 5'b11000);
      end else begin
         check({tag, ":err"}, {error, cpu_run, byte_ready, busy, done}, 5'b10000);
         @(negedge clk);
      end
      check({tag, ":nwrites"}, wr_q.size(), payload.size());
      bad = 0;
      foreach (payload[i]) begin
         a = base + 8'(i);
         if (i >= wr_q.size() || wr_q[i] !== {a, payload[i]}) bad++;
      end
      check({tag, ":write_errs"}, bad, 0);
      check({tag, ":npc"}, pc_q.size(), good ? 1 : 0);
      if (good && pc_q.size() > 0) check({tag, ":pc_q"}, pc_q[0], base);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b1; base_addr = 8'h55; len_m1 = 8'h3;
      byte_valid = 1'b1; byte_data = 8'h77;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      start = 1'b0; byte_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("idle");

      payload = '{8'h01, 8'h02, 8'h03};
      run_load(8'h10, 8'hFA, 0, 1'b0, "nominal");
      run_load(8'h10, 8'h00, 0, 1'b0, "badsum");
      payload = '{8'hAA, 8'hBB, 8'hCC};
      run_load(8'hFE, 8'hCF, 1, 1'b1, "wrap");

      // Stall in LOAD: error exactly TO cycles after the last accepted byte.
      pulse_start(8'h20, 8'h03);
      send(8'h11, 0);
      for (int j = 1; j <= TO; j++) begin
         @(negedge clk);
         check("stall_load_err", error, (j == TO) ? 1 : 0);
      end

      // A byte on the final stalled cycle beats the timeout; then time out in CHECK.
      pulse_start(8'h20, 8'h02);
      send(8'h11, 0);
      repeat (TO - 1) @(negedge clk);
      byte_valid = 1'b1; byte_data = 8'h22;
      @(negedge clk);
      byte_valid = 1'b0;
      check("stall_rescue", {error, busy, byte_ready}, 3'b011);
      check("stall_rescue_wr", {mem_we, mem_addr, mem_data}, {1'b1, 8'h21, 8'h22});
      send(8'h33, 0);
      for (int j = 1; j <= TO; j++) begin
         @(negedge clk);
         check("stall_check_err", error, (j == TO) ? 1 : 0);
      end

      // Reset on the edge that accepts the third of four bytes.
      wr_q.delete();
      pulse_start(8'h40, 8'h03);
      send(8'hA1, 0);
      send(8'hA2, 0);
      byte_valid = 1'b1; byte_data = 8'hA3; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; byte_valid = 1'b0;
      check_reset_vals("midreset");
      repeat (5) @(negedge clk);
      check("midreset_writes", wr_q.size(), 2);
      payload = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      run_load(8'h40, 8'h00 - 8'hA1 - 8'hA2 - 8'hA3 - 8'hA4, 0, 1'b0, "after_reset");

      for (int it = 0; it < 25; it++) begin
         int n;
         int s;
         logic [7:0] chk;
         logic e_run;
         logic e_err;
         int nw;
         n = (it == 10) ? 256 : int'($urandom_range(16, 1));
         payload.delete();
         s = 0;
         for (int k = 0; k < n; k++) begin
            payload.push_back(8'($urandom));
            s += int'(payload[k]);
         end
         chk = 8'(256 - (s % 256));
         if ($urandom_range(3, 0) == 0) chk = chk + 8'($urandom_range(255, 1));
         run_load(8'($urandom), chk, 3, 1'($urandom), "rand");
         if ($urandom_range(1, 0) == 1) begin
            e_run = cpu_run; e_err = error; nw = wr_q.size();
            byte_valid = 1'b1;
            repeat (3) begin
               byte_data = 8'($urandom);
               @(negedge clk);
            end
            byte_valid = 1'b0;
            check("ignored_bytes", wr_q.size(), nw);
            check("ignored_state", {cpu_run, error}, {e_run, e_err});
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
